// File: rtl/centipede_bus_pkg.sv
// Centipede 6502 bus map: slave ids, default decode windows and wait states.
// Pure constants; no logic, no latency, no stall behaviour.
package centipede_bus_pkg;

   localparam int BUS_NUM_SLAVES = 6;
   localparam int BUS_ADDR_W     = 16;
   localparam int BUS_DATA_W     = 8;
   localparam int BUS_WAIT_W     = 3;

   typedef enum logic [2:0] {
      RAM   = 3'd0,
      VIDEO = 3'd1,
      INPUT = 3'd2,
      POKEY = 3'd3,
      COLOR = 3'd4,
      ROM   = 3'd5
   } slave_e;

   typedef enum logic {
      S_ACCESS = 1'b0,
      S_WAIT   = 1'b1
   } fsm_e;

   // Concatenations list slave 5 (ROM) first so that index k selects slave k.
   localparam logic [BUS_NUM_SLAVES-1:0][BUS_ADDR_W-1:0] DEF_BASE =
      {16'h2000, 16'h1400, 16'h1000, 16'h0800, 16'h0400, 16'h0000};
   localparam logic [BUS_NUM_SLAVES-1:0][BUS_ADDR_W-1:0] DEF_MASK =
      {16'hE000, 16'hFFE0, 16'hFFF0, 16'hF800, 16'hFC00, 16'hFC00};
   localparam logic [BUS_NUM_SLAVES-1:0][BUS_WAIT_W-1:0] DEF_WAIT =
      {3'd1, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};

endpackage

// File: rtl/bus_decoder.sv
// Combinational priority address decoder: one-hot select, hit index, unmapped flag.
// Zero latency; no stall of its own, lowest-index window wins on overlap.
module bus_decoder #(
   parameter int NUM_SLAVES = 6,
   parameter int ADDR_W     = 16,
   parameter int IDX_W      = 3,
   parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] BASE = '0,
   parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] MASK = '0
) (
   input  logic [ADDR_W-1:0]     addr_i,
   output logic [NUM_SLAVES-1:0] sel_o,
   output logic [IDX_W-1:0]      idx_o,
   output logic                  unmapped_o
);

   always_comb begin
      sel_o      = '0;
      idx_o      = '0;
      unmapped_o = 1'b1;
      // Scan from the top down so the lowest matching index is the last writer.
      for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
         if ((addr_i & MASK[k]) == BASE[k]) begin
            sel_o      = '0;
            sel_o[k]   = 1'b1;
            idx_o      = IDX_W'(k);
            unmapped_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cpu_bus_fabric.sv
// 6502 bus fabric: decode, per-slave wait states via cpu_rdy, registered read mux; read
// latency 1+WAIT[k], write pulse after WAIT[k]. CPU_BUS_OPEN_BUS_EN keeps cpu_din on unmapped reads.
module cpu_bus_fabric
   import centipede_bus_pkg::*;
#(
   parameter int NUM_SLAVES = BUS_NUM_SLAVES,
   parameter int ADDR_W     = BUS_ADDR_W,
   parameter int DATA_W     = BUS_DATA_W,
   parameter int WAIT_W     = BUS_WAIT_W,
   parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] BASE = DEF_BASE,
   parameter logic [NUM_SLAVES-1:0][ADDR_W-1:0] MASK = DEF_MASK,
   parameter logic [NUM_SLAVES-1:0][WAIT_W-1:0] WAIT = DEF_WAIT
) (
   input  logic                         clk,
   input  logic                         rst_l,
   input  logic [ADDR_W-1:0]            cpu_addr,
   input  logic                         cpu_we_l,
   input  logic [DATA_W-1:0]            cpu_dout,
   output logic [DATA_W-1:0]            cpu_din,
   output logic                         cpu_rdy,
   output logic [NUM_SLAVES-1:0]        slv_sel,
   output logic                         slv_we,
   output logic [DATA_W-1:0]            slv_wdata,
   input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
   output logic                         unmapped
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   logic [NUM_SLAVES-1:0] dec_sel;
   logic [IDX_W-1:0]      dec_idx;
   logic                  dec_unmapped;

   fsm_e              state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_l_q;
   logic              live_q;

   logic              hit;
   logic              abort;
   logic              rdy_int;
   logic [WAIT_W-1:0] slv_wait;

   bus_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_W     (ADDR_W),
      .IDX_W      (IDX_W),
      .BASE       (BASE),
      .MASK       (MASK)
   ) u_dec (
      .addr_i     (cpu_addr),
      .sel_o      (dec_sel),
      .idx_o      (dec_idx),
      .unmapped_o (dec_unmapped)
   );

   assign hit      = ~dec_unmapped;
   assign slv_wait = hit ? WAIT[dec_idx] : '0;
   // The core must hold address and strobe through a stall; any change restarts the access.
   assign abort    = (cpu_addr != addr_q) || (cpu_we_l != we_l_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdy_int = 1'b1;
      if (!live_q) begin
         state_d = S_ACCESS;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_ACCESS: begin
               if (slv_wait != '0) begin
                  rdy_int = 1'b0;
                  cnt_d   = slv_wait - WAIT_W'(1);
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (abort) begin
                  rdy_int = 1'b0;
                  cnt_d   = '0;
                  state_d = S_ACCESS;
               end else if (cnt_q == '0) begin
                  state_d = S_ACCESS;
               end else begin
                  rdy_int = 1'b0;
                  cnt_d   = cnt_q - WAIT_W'(1);
               end
            end
            default: begin
               state_d = S_ACCESS;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      din_d = din_q;
      if (live_q && rdy_int) begin
         if (!cpu_we_l) begin
            din_d = cpu_dout;
         end else if (hit) begin
            din_d = slv_rdata[dec_idx*DATA_W +: DATA_W];
         end else begin
`ifdef CPU_BUS_OPEN_BUS_EN
            din_d = din_q;
`else
            din_d = '1;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= S_ACCESS;
         cnt_q   <= '0;
         din_q   <= '0;
         addr_q  <= '0;
         we_l_q  <= 1'b1;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         live_q  <= 1'b1;
         if (state_q == S_ACCESS) begin
            addr_q <= cpu_addr;
            we_l_q <= cpu_we_l;
         end
      end
   end

   assign cpu_din   = din_q;
   assign cpu_rdy   = rdy_int;
   assign slv_sel   = live_q ? dec_sel : '0;
   assign slv_we    = live_q & ~cpu_we_l & rdy_int & hit;
   assign slv_wdata = cpu_dout;
   assign unmapped  = live_q & dec_unmapped;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Directed bench for cpu_bus_fabric; read/write data expectations go through a scoreboard queue.
module tb_cpu_bus_fabric;

   logic        clk = 1'b0;
   logic        rst_l = 1'b1;
   logic [15:0] cpu_addr = '0;
   logic        cpu_we_l = 1'b1;
   logic [7:0]  cpu_dout = '0;
   logic [7:0]  cpu_din;
   logic        cpu_rdy;
   logic [5:0]  slv_sel;
   logic        slv_we;
   logic [7:0]  slv_wdata;
   logic [47:0] slv_rdata = '0;
   logic        unmapped;

   int errors = 0;
   int checks = 0;
   int we_pulses = 0;
   logic [7:0] sb[$];

   cpu_bus_fabric dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .cpu_addr  (cpu_addr),
      .cpu_we_l  (cpu_we_l),
      .cpu_dout  (cpu_dout),
      .cpu_din   (cpu_din),
      .cpu_rdy   (cpu_rdy),
      .slv_sel   (slv_sel),
      .slv_we    (slv_we),
      .slv_wdata (slv_wdata),
      .slv_rdata (slv_rdata),
      .unmapped  (unmapped)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (slv_we === 1'b1) we_pulses++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; any scoreboard entry is the value cpu_din must hold after that edge.
   task automatic tick();
      logic [7:0] e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("cpu_din", {24'h0, cpu_din}, {24'h0, e});
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic we_l, input logic [7:0] d);
      cpu_addr = a;
      cpu_we_l = we_l;
      cpu_dout = d;
      #1;
   endtask

   task automatic outs(input string tag, input logic rdy, input logic [5:0] sel,
                       input logic we, input logic um);
      chk({tag, ".rdy"}, {31'h0, cpu_rdy}, {31'h0, rdy});
      chk({tag, ".sel"}, {26'h0, slv_sel}, {26'h0, sel});
      chk({tag, ".we"},  {31'h0, slv_we},  {31'h0, we});
      chk({tag, ".unmapped"}, {31'h0, unmapped}, {31'h0, um});
   endtask

   initial begin
      logic [7:0] ub;
      // Reset state
      #2 rst_l = 1'b0;
      #1;
      chk("reset.din", {24'h0, cpu_din}, 32'h0);
      outs("reset", 1'b1, 6'b000000, 1'b0, 1'b0);
      @(posedge clk); #1;
      outs("reset_hold", 1'b1, 6'b000000, 1'b0, 1'b0);
      #5 rst_l = 1'b1;
      tick();

      // RAM read, zero wait
      slv_rdata[0*8 +: 8] = 8'h5A;
      drive(16'h0123, 1'b1, 8'h00);
      outs("ram_rd", 1'b1, 6'b000001, 1'b0, 1'b0);
      sb.push_back(8'h5A);
      tick();

      // POKEY write, two waits
      drive(16'h1005, 1'b0, 8'h3C);
      outs("pokey_wr.c1", 1'b0, 6'b001000, 1'b0, 1'b0);
      tick(); #1;
      outs("pokey_wr.c2", 1'b0, 6'b001000, 1'b0, 1'b0);
      tick(); #1;
      outs("pokey_wr.c3", 1'b1, 6'b001000, 1'b1, 1'b0);
      chk("pokey_wr.wdata", {24'h0, slv_wdata}, 32'h3C);
      sb.push_back(8'h3C);
      tick();

      // ROM read, one wait
      slv_rdata[5*8 +: 8] = 8'hA9;
      drive(16'h2FFF, 1'b1, 8'h00);
      outs("rom_rd.c1", 1'b0, 6'b100000, 1'b0, 1'b0);
      chk("rom_rd.din_hold", {24'h0, cpu_din}, 32'h3C);
      tick(); #1;
      outs("rom_rd.c2", 1'b1, 6'b100000, 1'b0, 1'b0);
      sb.push_back(8'hA9);
      tick();

      // RAM write then unmapped read
      drive(16'h0010, 1'b0, 8'h77);
      outs("ram_wr", 1'b1, 6'b000001, 1'b1, 1'b0);
      sb.push_back(8'h77);
      tick();
      drive(16'h1800, 1'b1, 8'h00);
      outs("unmapped_rd", 1'b1, 6'b000000, 1'b0, 1'b1);
`ifdef CPU_BUS_OPEN_BUS_EN
      ub = 8'h77;
`else
      ub = 8'hFF;
`endif
      sb.push_back(ub);
      tick();

      // Back-to-back zero-wait reads across RAM, VIDEO, INPUT, COLOR
      slv_rdata[0*8 +: 8] = 8'h01;
      slv_rdata[1*8 +: 8] = 8'hC3;
      slv_rdata[2*8 +: 8] = 8'h4E;
      slv_rdata[4*8 +: 8] = 8'h9D;
      drive(16'h03FF, 1'b1, 8'h00);
      outs("b2b.ram", 1'b1, 6'b000001, 1'b0, 1'b0);
      sb.push_back(8'h01);
      tick();
      drive(16'h0400, 1'b1, 8'h00);
      outs("b2b.video", 1'b1, 6'b000010, 1'b0, 1'b0);
      sb.push_back(8'hC3);
      tick();
      drive(16'h0FFF, 1'b1, 8'h00);
      outs("b2b.input", 1'b1, 6'b000100, 1'b0, 1'b0);
      sb.push_back(8'h4E);
      tick();
      drive(16'h141F, 1'b1, 8'h00);
      outs("b2b.color", 1'b1, 6'b010000, 1'b0, 1'b0);
      sb.push_back(8'h9D);
      tick();

      // Reset during the first POKEY wait cycle
      drive(16'h1000, 1'b0, 8'h11);
      outs("rst_wr.c1", 1'b0, 6'b001000, 1'b0, 1'b0);
      rst_l = 1'b0;
      #1;
      chk("rst_wr.din", {24'h0, cpu_din}, 32'h0);
      outs("rst_wr.async", 1'b1, 6'b000000, 1'b0, 1'b0);
      @(posedge clk); #1;
      outs("rst_wr.hold", 1'b1, 6'b000000, 1'b0, 1'b0);
      drive(16'h0123, 1'b1, 8'h00);
      rst_l = 1'b1;
      tick();

      // Address change mid-wait aborts the POKEY write
      slv_rdata[0*8 +: 8] = 8'h66;
      drive(16'h1000, 1'b0, 8'h22);
      outs("abort.c1", 1'b0, 6'b001000, 1'b0, 1'b0);
      tick();
      drive(16'h0010, 1'b1, 8'h00);
      chk("abort.change.rdy", {31'h0, cpu_rdy}, 32'h0);
      chk("abort.change.we", {31'h0, slv_we}, 32'h0);
      tick(); #1;
      outs("abort.ram", 1'b1, 6'b000001, 1'b0, 1'b0);
      sb.push_back(8'h66);
      tick();

      // Only the POKEY and RAM writes ever pulse slv_we
      chk("we_pulse_count", we_pulses, 32'd2);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
